convclk_grayfwft_rd: RTL and testbench
======================================

CONVCLK_GRAYFWFT_RD -- requirements
Module: convclk_grayfwft_rd

Interface
REQ-001 Parameter ADDRB, default 4, RAM address width; pointers are ADDRB+1 bits.
REQ-002 Parameter DATAW, default 8, data width.
REQ-003 rdclk  input  1  read-domain clock; all flops on rising edge.
REQ-004 rdrst_  input  1  asynchronous active-low reset.
REQ-005 fifoflush  input  1  synchronous flush, rdclk domain.
REQ-006 wrpnt_gray  input  ADDRB+1  Gray write pointer from the write-domain controller; asynchronous to rdclk.
REQ-007 rdpnt_gray  output  ADDRB+1  registered Gray read pointer, sent to the write domain.
REQ-008 read  output  1  RAM read strobe, combinational.
REQ-009 rdaddr  output  ADDRB  RAM read address, equal to rdpnt_bin[ADDRB-1:0].
REQ-010 rddata  input  DATAW  RAM read data, valid in the cycle after the edge that samples read.
REQ-011 dout  output  DATAW  head-of-queue data, first-word-fall-through.
REQ-012 dvalid  output  1  dout valid.
REQ-013 dready  input  1  consumer accept; a pop occurs on dvalid & dready.
REQ-014 fifoempty  output  1  RAM region empty (rdpnt_bin == wrpnt_bin).
REQ-015 rdfifolen  output  ADDRB+1  words resident in RAM, equal to wrpnt_bin - rdpnt_bin, modulo 2^(ADDRB+1).

Function
REQ-016 Synchronise wrpnt_gray through two flops (sync1, sync2); decode sync2 to binary wrpnt_bin, where bit i is the XOR of sync2 bits ADDRB down to i.
REQ-017 Keep a binary read pointer rdpnt_bin of ADDRB+1 bits; it increments by 1 on each cycle with read=1 and wraps from 2^(ADDRB+1)-1 to 0.
REQ-018 rdpnt_gray is registered each cycle as rdpnt_bin ^ (rdpnt_bin>>1), so it lags rdpnt_bin by one cycle.
REQ-019 Output stage: a 2-entry buffer with occupancy count cnt in 0..2 and a one-cycle in-flight flag infl.
REQ-020 read = ~fifoempty & ~fifoflush & ((cnt + infl - pop) < 2), so the buffer never overflows.
REQ-021 infl is registered each cycle from read.
REQ-022 When infl=1, rddata is written into the buffer at the next edge, behind any retained entry.
REQ-023 A push and a pop in the same cycle leave cnt unchanged; ordering is preserved.
REQ-024 dvalid = (cnt != 0); dout = head entry; dout holds stable while dvalid & ~dready.
REQ-025 Latency: if wrpnt_gray changes before edge 1 with the block idle and empty, read is high in the cycle after edge 2, data is captured at edge 4, and dvalid is high after edge 4.
REQ-026 With dready held at 1 and the RAM continuously non-empty, throughput is one word per cycle.
REQ-027 Flush: at the edge where fifoflush=1, rdpnt_bin, cnt and infl clear to 0 and RAM data still in flight is discarded; rdpnt_gray clears at the following edge.
REQ-028 A flush overrides a simultaneous read, push or pop.
REQ-029 Full-range wrap: when rdfifolen = 2^ADDRB, fifoempty=0, and reads continue across the wrap of rdaddr.
REQ-030 A wrpnt_gray value that is not Gray-adjacent is not corrected; the write side guarantees a single-bit change per write clock.

Reset
REQ-031 While rdrst_=0: sync1, sync2, rdpnt_bin, rdpnt_gray, cnt, infl and the buffer are 0; dvalid=0, read=0, fifoempty=1, rdfifolen=0, dout=0.
REQ-032 Reset asserted mid-transfer takes effect immediately without waiting for a clock edge; in-flight data is lost.
REQ-033 After deassertion, the first read occurs no earlier than the third edge, because sync2 must see a non-zero write pointer.

Verification
REQ-034 Reset, then wrpnt_gray 00000 -> 00001 -> dvalid rises after edge 4; dout = RAM[0]; rdfifolen reaches 1 and then returns to 0.
REQ-035 16 words loaded with dready=0 -> read fires exactly twice; cnt=2; rdfifolen=14; dout = word 0 held stable.
REQ-036 16 words loaded, then dready=1 continuous -> 16 consecutive dvalid beats in order; rdpnt_gray ends at 11000 (binary 16).
REQ-037 Random dready over 100 words with pointer wrap -> no loss, no duplication, in order; rdaddr wraps from 15 to 0.
REQ-038 fifoflush pulsed while infl=1 and cnt=1 -> next cycle dvalid=0 and rdpnt_bin=0; the discarded rddata never appears on dout.
REQ-039 rdrst_ pulsed low mid-stream -> all outputs are at their REQ-031 reset values asynchronously.

Source files
------------

// File: rtl/convclk_grayfwft_rd.sv
// Read side of a dual-clock Gray-pointer FIFO with a 2-entry first-word-fall-through output stage.
// Latency: write pointer to dvalid is 4 rdclk edges (2 sync + RAM read + capture); 1 word/cycle sustained.
// Backpressure: dready low holds dout; RAM reads stop once the buffer plus the in-flight word would fill it.
module convclk_grayfwft_rd #(
    parameter int ADDRB = 4,
    parameter int DATAW = 8
) (
    input  logic             rdclk,
    input  logic             rdrst_,
    input  logic             fifoflush,
    input  logic [ADDRB:0]   wrpnt_gray,
    output logic [ADDRB:0]   rdpnt_gray,
    output logic             read,
    output logic [ADDRB-1:0] rdaddr,
    input  logic [DATAW-1:0] rddata,
    output logic [DATAW-1:0] dout,
    output logic             dvalid,
    input  logic             dready,
    output logic             fifoempty,
    output logic [ADDRB:0]   rdfifolen
);

    logic [ADDRB:0]   sync1;
    logic [ADDRB:0]   sync2;
    logic [ADDRB:0]   wrpnt_bin;
    logic [ADDRB:0]   rdpnt_bin;
    logic [1:0]       cnt;
    logic             infl;
    logic             pop;
    logic [2:0]       occ_next;
    logic [DATAW-1:0] buf0;
    logic [DATAW-1:0] buf1;

    // Two-flop synchroniser; the write side only ever changes one Gray bit per write clock.
    always_ff @(posedge rdclk or negedge rdrst_) begin
        if (!rdrst_) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= wrpnt_gray;
            sync2 <= sync1;
        end
    end

    always_comb begin
        wrpnt_bin = '0;
        for (int i = 0; i <= ADDRB; i++) begin
            wrpnt_bin[i] = ^(sync2 >> i);
        end
    end

    assign fifoempty = (rdpnt_bin == wrpnt_bin);
    assign rdfifolen = wrpnt_bin - rdpnt_bin;
    assign rdaddr    = rdpnt_bin[ADDRB-1:0];
    assign dvalid    = (cnt != 2'd0);
    assign dout      = buf0;
    assign pop       = dvalid & dready;

    // Occupancy the buffer will have after this edge if no new read is issued.
    always_comb begin
        occ_next = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
        read     = ~fifoempty & ~fifoflush & (occ_next < 3'd2);
    end

    always_ff @(posedge rdclk or negedge rdrst_) begin
        if (!rdrst_) begin
            rdpnt_bin  <= '0;
            rdpnt_gray <= '0;
            infl       <= 1'b0;
        end else begin
            rdpnt_gray <= rdpnt_bin ^ (rdpnt_bin >> 1);
            if (fifoflush) begin
                rdpnt_bin <= '0;
                infl      <= 1'b0;
            end else begin
                if (read) begin
                    rdpnt_bin <= rdpnt_bin + 1'b1;
                end
                infl <= read;
            end
        end
    end

    // buf0 is the head; a word arriving from RAM lands behind any entry still held.
    always_ff @(posedge rdclk or negedge rdrst_) begin
        if (!rdrst_) begin
            cnt  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else if (fifoflush) begin
            cnt  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({infl, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        buf0 <= rddata;
                    end else begin
                        buf1 <= rddata;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        buf0 <= rddata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= rddata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_convclk_grayfwft_rd.sv
// Directed bench for convclk_grayfwft_rd: a behavioural RAM model plus hand-computed expectations per scenario.
module tb_convclk_grayfwft_rd;

    logic       rdclk;
    logic       rdrst_;
    logic       fifoflush;
    logic [4:0] wrpnt_gray;
    logic [4:0] rdpnt_gray;
    logic       read;
    logic [3:0] rdaddr;
    logic [7:0] rddata;
    logic [7:0] dout;
    logic       dvalid;
    logic       dready;
    logic       fifoempty;
    logic [4:0] rdfifolen;

    logic [7:0] ram [16];
    logic [4:0] wr_bin;
    int         errors;
    int         checks;

    convclk_grayfwft_rd #(.ADDRB(4), .DATAW(8)) dut (
        .rdclk      (rdclk),
        .rdrst_     (rdrst_),
        .fifoflush  (fifoflush),
        .wrpnt_gray (wrpnt_gray),
        .rdpnt_gray (rdpnt_gray),
        .read       (read),
        .rdaddr     (rdaddr),
        .rddata     (rddata),
        .dout       (dout),
        .dvalid     (dvalid),
        .dready     (dready),
        .fifoempty  (fifoempty),
        .rdfifolen  (rdfifolen)
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    always @(posedge rdclk) begin
        if (read) rddata <= ram[rdaddr];
    end

    function automatic logic [4:0] bin2gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] gray2bin(input logic [4:0] g);
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [7:0] rnd_word(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return kb ^ 8'hA5;
    endfunction

    task automatic tick;
        @(posedge rdclk);
        #1;
    endtask

    task automatic set_wr(input logic [4:0] b);
        wr_bin     = b;
        wrpnt_gray = bin2gray(b);
    endtask

    task automatic do_reset;
        rdrst_    = 1'b0;
        fifoflush = 1'b0;
        dready    = 1'b0;
        set_wr(5'd0);
        repeat (2) tick;
        rdrst_ = 1'b1;
    endtask

    task automatic test_reset;
        rdrst_     = 1'b0;
        fifoflush  = 1'b0;
        dready     = 1'b1;
        wrpnt_gray = 5'b10101;
        repeat (3) tick;
        checks++; if (dvalid !== 1'b0)       begin errors++; $display("FAIL reset_dvalid got %0h expected 0", dvalid); end
        checks++; if (read !== 1'b0)         begin errors++; $display("FAIL reset_read got %0h expected 0", read); end
        checks++; if (fifoempty !== 1'b1)    begin errors++; $display("FAIL reset_fifoempty got %0h expected 1", fifoempty); end
        checks++; if (rdfifolen !== 5'd0)    begin errors++; $display("FAIL reset_rdfifolen got %0h expected 0", rdfifolen); end
        checks++; if (dout !== 8'h00)        begin errors++; $display("FAIL reset_dout got %0h expected 0", dout); end
        checks++; if (rdpnt_gray !== 5'd0)   begin errors++; $display("FAIL reset_rdpnt_gray got %0h expected 0", rdpnt_gray); end
        checks++; if (rdaddr !== 4'd0)       begin errors++; $display("FAIL reset_rdaddr got %0h expected 0", rdaddr); end
    endtask

    task automatic test_latency;
        do_reset;
        ram[0] = 8'hA5;
        set_wr(5'd1);
        tick;
        checks++; if (read !== 1'b0 || fifoempty !== 1'b1) begin errors++; $display("FAIL lat_edge1 got read=%0h empty=%0h expected 0/1", read, fifoempty); end
        tick;
        checks++; if (read !== 1'b1 || rdfifolen !== 5'd1) begin errors++; $display("FAIL lat_edge2 got read=%0h len=%0d expected 1/1", read, rdfifolen); end
        tick;
        checks++; if (read !== 1'b0 || rdfifolen !== 5'd0 || dvalid !== 1'b0) begin errors++; $display("FAIL lat_edge3 got read=%0h len=%0d dvalid=%0h expected 0/0/0", read, rdfifolen, dvalid); end
        tick;
        checks++; if (dvalid !== 1'b1 || dout !== 8'hA5) begin errors++; $display("FAIL lat_edge4 got dvalid=%0h dout=%0h expected 1/a5", dvalid, dout); end
        checks++; if (rdpnt_gray !== 5'd1) begin errors++; $display("FAIL lat_rdpnt_gray got %0h expected 1", rdpnt_gray); end
        dready = 1'b1;
        tick;
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL lat_pop got dvalid=%0h expected 0", dvalid); end
    endtask

    task automatic test_backpressure;
        int         reads;
        logic       seen;
        logic       stable;
        logic [7:0] first;
        do_reset;
        for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
        set_wr(5'd16);
        repeat (2) tick;
        checks++; if (fifoempty !== 1'b0 || rdfifolen !== 5'd16) begin errors++; $display("FAIL bp_fullrange got empty=%0h len=%0d expected 0/16", fifoempty, rdfifolen); end
        reads  = 0;
        seen   = 1'b0;
        stable = 1'b1;
        first  = 8'h00;
        for (int c = 0; c < 12; c++) begin
            if (read) reads++;
            if (dvalid) begin
                if (!seen) begin
                    first = dout;
                    seen  = 1'b1;
                end else if (dout !== first) begin
                    stable = 1'b0;
                end
            end
            tick;
        end
        checks++; if (reads != 2)          begin errors++; $display("FAIL bp_reads got %0d expected 2", reads); end
        checks++; if (rdfifolen !== 5'd14) begin errors++; $display("FAIL bp_rdfifolen got %0d expected 14", rdfifolen); end
        checks++; if (dvalid !== 1'b1 || dout !== 8'h10) begin errors++; $display("FAIL bp_head got dvalid=%0h dout=%0h expected 1/10", dvalid, dout); end
        checks++; if (stable !== 1'b1)     begin errors++; $display("FAIL bp_stable got %0h expected 1", stable); end
    endtask

    task automatic test_back_to_back;
        int         n;
        int         first_c;
        int         last_c;
        logic [7:0] e;
        dready  = 1'b1;
        n       = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 40; c++) begin
            if (dvalid) begin
                e = 8'h10 + 8'(n);
                checks++; if (dout !== e) begin errors++; $display("FAIL b2b_beat%0d got %0h expected %0h", n, dout, e); end
                if (n == 0) first_c = c;
                last_c = c;
                n++;
            end
            tick;
        end
        checks++; if (n != 16)                  begin errors++; $display("FAIL b2b_count got %0d expected 16", n); end
        checks++; if (last_c - first_c != 15)  begin errors++; $display("FAIL b2b_span got %0d expected 15", last_c - first_c); end
        checks++; if (rdpnt_gray !== 5'b11000) begin errors++; $display("FAIL b2b_rdpnt_gray got %b expected 11000", rdpnt_gray); end
        checks++; if (fifoempty !== 1'b1)      begin errors++; $display("FAIL b2b_empty got %0h expected 1", fifoempty); end
    endtask

    task automatic test_random_wrap;
        int         sent;
        int         got;
        logic       saw15;
        logic       wrapped;
        logic       hold;
        logic [7:0] held;
        logic [4:0] occ;
        logic [7:0] e;
        do_reset;
        sent    = 0;
        got     = 0;
        saw15   = 1'b0;
        wrapped = 1'b0;
        hold    = 1'b0;
        held    = 8'h00;
        for (int c = 0; c < 3000 && got < 100; c++) begin
            if (hold) begin
                checks++; if (dout !== held) begin errors++; $display("FAIL rnd_hold got %0h expected %0h", dout, held); end
            end
            dready = 1'($urandom_range(0, 1));
            if (dvalid && dready) begin
                e = rnd_word(got);
                checks++; if (dout !== e) begin errors++; $display("FAIL rnd_word%0d got %0h expected %0h", got, dout, e); end
                got++;
            end
            hold = dvalid & ~dready;
            held = dout;
            if (rdaddr == 4'd15) begin
                saw15 = 1'b1;
            end else begin
                if (saw15 && rdaddr == 4'd0) wrapped = 1'b1;
                saw15 = 1'b0;
            end
            occ = wr_bin - gray2bin(rdpnt_gray);
            if (sent < 100 && occ < 5'd16) begin
                ram[wr_bin[3:0]] = rnd_word(sent);
                set_wr(wr_bin + 5'd1);
                sent++;
            end
            tick;
        end
        checks++; if (got != 100)      begin errors++; $display("FAIL rnd_received got %0d expected 100", got); end
        checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL rnd_rdaddr_wrap got %0h expected 1", wrapped); end
        dready = 1'b1;
        repeat (4) tick;
        checks++; if (dvalid !== 1'b0 || fifoempty !== 1'b1) begin errors++; $display("FAIL rnd_drained got dvalid=%0h empty=%0h expected 0/1", dvalid, fifoempty); end
    endtask

    task automatic test_flush;
        logic leaked;
        do_reset;
        ram[0] = 8'h11;
        ram[1] = 8'h22;
        set_wr(5'd2);
        repeat (4) tick;
        checks++; if (dvalid !== 1'b1 || dout !== 8'h11) begin errors++; $display("FAIL fl_pre got dvalid=%0h dout=%0h expected 1/11", dvalid, dout); end
        fifoflush = 1'b1;
        ram[0]    = 8'h33;
        ram[1]    = 8'h44;
        tick;
        fifoflush = 1'b0;
        leaked    = (dout === 8'h22);
        checks++; if (dvalid !== 1'b0 || rdaddr !== 4'd0) begin errors++; $display("FAIL fl_clear got dvalid=%0h rdaddr=%0h expected 0/0", dvalid, rdaddr); end
        checks++; if (rdpnt_gray !== 5'b00011) begin errors++; $display("FAIL fl_gray_lag got %b expected 00011", rdpnt_gray); end
        tick;
        if (dout === 8'h22) leaked = 1'b1;
        checks++; if (rdpnt_gray !== 5'b00000) begin errors++; $display("FAIL fl_gray_clear got %b expected 00000", rdpnt_gray); end
        tick;
        if (dout === 8'h22) leaked = 1'b1;
        checks++; if (dvalid !== 1'b1 || dout !== 8'h33) begin errors++; $display("FAIL fl_refetch got dvalid=%0h dout=%0h expected 1/33", dvalid, dout); end
        for (int c = 0; c < 6; c++) begin
            tick;
            if (dout === 8'h22) leaked = 1'b1;
        end
        checks++; if (leaked !== 1'b0) begin errors++; $display("FAIL fl_discard got leaked=%0h expected 0", leaked); end
    endtask

    task automatic test_async_reset;
        do_reset;
        for (int i = 0; i < 16; i++) ram[i] = 8'h40 + 8'(i);
        dready = 1'b1;
        set_wr(5'd16);
        repeat (6) tick;
        checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL ar_midstream got dvalid=%0h expected 1", dvalid); end
        #3;
        rdrst_ = 1'b0;
        #1;
        checks++; if (dvalid !== 1'b0 || read !== 1'b0) begin errors++; $display("FAIL ar_ctrl got dvalid=%0h read=%0h expected 0/0", dvalid, read); end
        checks++; if (fifoempty !== 1'b1 || rdfifolen !== 5'd0) begin errors++; $display("FAIL ar_level got empty=%0h len=%0d expected 1/0", fifoempty, rdfifolen); end
        checks++; if (dout !== 8'h00 || rdpnt_gray !== 5'd0 || rdaddr !== 4'd0) begin errors++; $display("FAIL ar_data got dout=%0h gray=%0h rdaddr=%0h expected 0/0/0", dout, rdpnt_gray, rdaddr); end
        tick;
        set_wr(5'd0);
        rdrst_ = 1'b1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rdrst_    = 1'b0;
        fifoflush = 1'b0;
        dready    = 1'b0;
        rddata    = 8'h00;
        wr_bin    = 5'd0;
        wrpnt_gray = 5'd0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        test_reset;
        test_latency;
        test_backpressure;
        test_back_to_back;
        test_random_wrap;
        test_flush;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
